// File: rtl/div_seq_if.sv
// Operand/result bundle for the sequential divider; master is the control unit.
// No backpressure: start is a request pulse, done is a one-cycle completion strobe.
interface div_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/div_seq.sv
// Signed restoring divider (MIPS DIV): lo=quotient, hi=remainder; done WIDTH+3 cycles after start.
// No backpressure: start outside idle is dropped; b==0 finishes in 2 cycles with div_zero.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    div_seq_if.slave  dv
);
    typedef enum logic [2:0] {IDLE, RUN, FIX, DONE, ZERO} state_t;

    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    state_t           state_q, state_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] rem_sh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        a_d        = a_q;
        b_d        = b_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        rem_sh     = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};

        case (state_q)
            IDLE: begin
                // Operands are captured on the start edge and dispatched one cycle later.
                if (pend_q) begin
                    pend_d = 1'b0;
                    if (b_q == '0) begin
                        div_zero_d = 1'b1;
                        state_d    = ZERO;
                    end else begin
                        quo_d     = a_q[WIDTH-1] ? -a_q : a_q;
                        dvs_d     = b_q[WIDTH-1] ? -b_q : b_q;
                        rem_d     = '0;
                        neg_quo_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
                        neg_rem_d = a_q[WIDTH-1];
                        cnt_d     = '0;
                        state_d   = RUN;
                    end
                end else if (dv.start) begin
                    a_d        = dv.a;
                    b_d        = dv.b;
                    div_zero_d = 1'b0;
                    pend_d     = 1'b1;
                end
            end
            RUN: begin
                // |b| <= 2^(WIDTH-1) keeps the shifted remainder within WIDTH bits.
                if (rem_sh >= dvs_q) begin
                    rem_d = rem_sh - dvs_q;
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh;
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                lo_d    = neg_quo_q ? -quo_q : quo_q;
                hi_d    = neg_rem_q ? -rem_q : rem_q;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            ZERO: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign dv.hi       = hi_q;
    assign dv.lo       = lo_q;
    assign dv.busy     = (state_q == RUN) || (state_q == FIX);
    assign dv.done     = (state_q == DONE) || (state_q == ZERO);
    assign dv.div_zero = div_zero_q;
endmodule

// File: tb/tb_div_seq.sv
// Directed checks of div_seq: signed results, fixed latency, divide-by-zero, ignored start, reset abort.
module tb_div_seq;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    div_seq_if #(.WIDTH(32)) dif ();
    div_seq #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .dv(dif));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start and watch until done; lat counts edges after the start edge.
    task automatic run_div(input logic [31:0] av, input logic [31:0] bv, input int inj,
                           output int lat, output int bcnt, output logic dz0);
        dif.start = 1'b1;
        dif.a     = av;
        dif.b     = bv;
        tick();
        dif.start = 1'b0;
        lat  = -1;
        bcnt = 0;
        dz0  = dif.div_zero;
        for (int n = 0; n < 60; n++) begin
            if (n == inj) begin
                dif.start = 1'b1;
                dif.a     = 32'd1;
                dif.b     = 32'd1;
            end else begin
                dif.start = 1'b0;
            end
            if (dif.busy) bcnt++;
            if (dif.done) begin
                lat = n;
                break;
            end
            tick();
        end
        dif.start = 1'b0;
    endtask

    int   lat;
    int   bcnt;
    logic dz0;
    int   done_seen;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        dif.start = 1'b0;
        dif.a     = '0;
        dif.b     = '0;
        #12;
        chk("rst_hi", dif.hi, 0);
        chk("rst_lo", dif.lo, 0);
        chk("rst_busy", dif.busy, 0);
        chk("rst_done", dif.done, 0);
        chk("rst_dz", dif.div_zero, 0);
        reset = 1'b0;
        tick();

        run_div(32'd7, 32'd2, -1, lat, bcnt, dz0);
        chk("7/2_lat", lat, 34);
        chk("7/2_busy", bcnt, 33);
        chk("7/2_lo", dif.lo, 3);
        chk("7/2_hi", dif.hi, 1);
        chk("7/2_dz", dif.div_zero, 0);
        tick();
        chk("7/2_done_pulse", dif.done, 0);

        run_div(32'hFFFF_FFF9, 32'd2, -1, lat, bcnt, dz0);
        chk("-7/2_lo", dif.lo, 64'hFFFF_FFFD);
        chk("-7/2_hi", dif.hi, 64'hFFFF_FFFF);
        tick();

        run_div(32'd7, 32'hFFFF_FFFE, -1, lat, bcnt, dz0);
        chk("7/-2_lo", dif.lo, 64'hFFFF_FFFD);
        chk("7/-2_hi", dif.hi, 1);
        tick();

        run_div(32'd7, 32'd2, -1, lat, bcnt, dz0);
        tick();
        run_div(32'd5, 32'd0, -1, lat, bcnt, dz0);
        chk("div0_lat", lat, 1);
        chk("div0_busy", bcnt, 0);
        chk("div0_flag", dif.div_zero, 1);
        chk("div0_lo", dif.lo, 3);
        chk("div0_hi", dif.hi, 1);
        tick();
        chk("div0_done_pulse", dif.done, 0);
        tick();
        tick();
        chk("div0_sticky", dif.div_zero, 1);

        run_div(32'd100, 32'd7, 5, lat, bcnt, dz0);
        chk("ign_dz_clr", dz0, 0);
        chk("ign_lat", lat, 34);
        chk("ign_lo", dif.lo, 14);
        chk("ign_hi", dif.hi, 2);
        tick();

        run_div(32'h8000_0000, 32'hFFFF_FFFF, -1, lat, bcnt, dz0);
        chk("ovf_lo", dif.lo, 64'h8000_0000);
        chk("ovf_hi", dif.hi, 0);
        chk("ovf_dz", dif.div_zero, 0);
        tick();

        run_div(32'd100, 32'd7, -1, lat, bcnt, dz0);
        tick();
        dif.start = 1'b1;
        dif.a     = 32'd100;
        dif.b     = 32'd7;
        tick();
        dif.start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #3;
        reset = 1'b1;
        #1;
        chk("rst_mid_lo", dif.lo, 0);
        chk("rst_mid_hi", dif.hi, 0);
        chk("rst_mid_busy", dif.busy, 0);
        #10;
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dif.done) done_seen++;
        end
        chk("rst_no_done", done_seen, 0);
        run_div(32'd100, 32'd7, -1, lat, bcnt, dz0);
        chk("post_rst_lat", lat, 34);
        chk("post_rst_lo", dif.lo, 14);
        chk("post_rst_hi", dif.hi, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: division request from the control unit, sampled on rising clk.
REQ-005 The block SHALL have port a, input, WIDTH bits: signed dividend (register A value).
REQ-006 The block SHALL have port b, input, WIDTH bits: signed divisor (register B value).
REQ-007 The block SHALL have port hi, output, WIDTH bits: signed remainder, feeding the HI register mux.
REQ-008 The block SHALL have port lo, output, WIDTH bits: signed quotient, feeding the LO register mux.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port div_zero, output, 1 bit: divide-by-zero flag for the exception logic.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, RUN, FIX, DONE, ZERO.
REQ-013 In IDLE with start=1, the block SHALL latch a and b, clear div_zero, and go to ZERO if b==0, else go to RUN.
REQ-014 On entry to RUN, the block SHALL load |a| into the quotient shifter, clear the partial remainder, load |b| into the divisor register, record sign_q = a[MSB]^b[MSB] and sign_r = a[MSB], and clear a 6-bit iteration counter.
REQ-015 In RUN, each cycle SHALL perform one restoring step: shift {rem,quo} left 1; if rem >= divisor, subtract divisor and set quo[0]=1.
REQ-016 The block SHALL perform exactly WIDTH RUN iterations, then go to FIX.
REQ-017 In FIX, the block SHALL load lo = sign_q ? -quo : quo and hi = sign_r ? -rem : rem, using two's complement modulo 2^WIDTH, then go to DONE.
REQ-018 In DONE, the block SHALL drive done=1 for exactly one cycle and return to IDLE.
REQ-019 Quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend (MIPS DIV semantics).
REQ-020 For a=0x80000000, b=0xFFFFFFFF, the block SHALL produce lo=0x80000000 and hi=0 with no error flag.
REQ-021 In ZERO, the block SHALL drive div_zero=1 and done=1 for one cycle, leave hi/lo unchanged, and return to IDLE.
REQ-022 div_zero SHALL remain high after ZERO until the next accepted start or reset.
REQ-023 Latency SHALL be fixed: with start sampled at edge k and b!=0, hi/lo SHALL be valid and done=1 in the cycle after edge k+WIDTH+2 (k+34 for WIDTH=32).
REQ-024 With b==0, done and div_zero SHALL both be high in the cycle after edge k+1.
REQ-025 busy SHALL be high in RUN and FIX, and low in IDLE, DONE and ZERO.
REQ-026 start asserted in any state other than IDLE SHALL be ignored, with no effect on operands or timing.
REQ-027 start held high continuously SHALL cause a new division to be accepted on the first IDLE cycle after each DONE/ZERO.
REQ-028 hi and lo SHALL hold their last result until overwritten in FIX.
REQ-029 Inputs a and b SHALL NOT affect an operation after the start sampling edge.

Reset
REQ-030 When reset is high, asynchronously and regardless of state, the block SHALL force the FSM to IDLE, set hi=0, lo=0, busy=0, done=0 and div_zero=0, and clear all internal registers.
REQ-031 A reset during RUN or FIX SHALL abort the division with no done pulse.
REQ-032 After reset deasserts, the block SHALL accept start on the first rising clk edge.

Verification
REQ-033 The bench SHALL cover: a=7, b=2, start 1 cycle -> done after 34 cycles, lo=3, hi=1, busy high for 33 cycles.
REQ-034 The bench SHALL cover: a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; and a=7, b=-2 -> lo=0xFFFFFFFD, hi=1.
REQ-035 The bench SHALL cover: previous result lo=3/hi=1, then a=5, b=0 -> done and div_zero high 1 cycle after start, lo=3, hi=1 unchanged, div_zero stays high until the next start.
REQ-036 The bench SHALL cover: a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-037 The bench SHALL cover: start a=100, b=7, then pulse start with a=1, b=1 at cycle 5 -> that start is ignored, result lo=14, hi=2 at cycle 34.
REQ-038 The bench SHALL cover: start a=100, b=7, reset asserted mid-cycle at cycle 10 -> outputs 0 immediately, no done pulse, and a new start after release completes normally.
